nibble_serial_subtractor: RTL

- Multi-cycle WIDTH-bit subtractor computing A - B - bin, one 4-bit nibble per clock.
- Each nibble uses borrow-lookahead logic; a registered borrow chains nibble to nibble.
- Sits beside the combinational 4-bit lookahead adder in the arithmetic library, as the inverse (subtract) direction for wide operands where area matters more than latency.
- Valid/ready handshake on both input and output.

---
 rtl/nibble_serial_subtractor_pkg.sv | 21 ++
 rtl/nibble_serial_subtractor_bl_subtractor4.sv | 46 ++++
 rtl/nibble_serial_subtractor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared types and constants for the nibble-serial subtractor
//
// Purpose : nibble width, FSM state type and nibble-count helper shared by
//           the top level and its borrow-lookahead slice.
// Ports   : none (package).
package nibble_serial_subtractor_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of 4-bit slices needed to cover a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_bl_subtractor4.sv
// rtl/nibble_serial_subtractor_bl_subtractor4.sv - combinational 4-bit borrow-lookahead subtractor
//
// Purpose : d = a - b - bin over one nibble, every internal borrow in
//           flattened lookahead form (no ripple between bits).
// Ports   : a, b     - nibble minuend / subtrahend
//           bin      - borrow into bit 0
//           d        - nibble difference
//           bout     - borrow out of bit 3
//           grp_p    - group propagate (borrow passes straight through)
//           grp_g    - group generate (nibble borrows on its own)
module bl_subtractor4
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             bin,
  output logic [NIB_W-1:0] d,
  output logic             bout,
  output logic             grp_p,
  output logic             grp_g
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   br;

  // A bit generates a borrow when a=0,b=1; it propagates one when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign br[4] = grp_g | (grp_p & bin);
  assign bout  = br[4];

  assign d = a ^ b ^ br[NIB_W-1:0];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle WIDTH-bit subtractor, one nibble per clock
//
// Purpose : computes a - b - bin over NIB = WIDTH/4 clock cycles using a
//           single borrow-lookahead nibble slice and a registered borrow.
//           Optional zero/overflow flags are built only when the macro
//           NIBBLE_SUB_FLAGS_EN is defined; otherwise zero/ovf read 0.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid, in_ready  - operand handshake (accepted only in IDLE)
//           a, b, bin           - minuend, subtrahend, borrow in
//           out_valid,out_ready - result handshake
//           diff, bout          - a - b - bin mod 2^WIDTH, unsigned borrow out
//           zero, ovf           - diff==0 and signed overflow (flag build only)
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             bout_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_d;
  logic             nib_bout;
  logic             nib_grp_p;
  logic             nib_grp_g;
  logic             unused_grp;

  assign nib_a = a_q[NIB_W*int'(idx_q) +: NIB_W];
  assign nib_b = b_q[NIB_W*int'(idx_q) +: NIB_W];

  bl_subtractor4 u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .bin   (br_q),
    .d     (nib_d),
    .bout  (nib_bout),
    .grp_p (nib_grp_p),
    .grp_g (nib_grp_g)
  );

  // Group signals are only needed when slices are cascaded combinationally;
  // here the chain runs through br_q instead.
  assign unused_grp = nib_grp_p ^ nib_grp_g;

  // diff with the current nibble merged in; on the last CALC cycle this is
  // the final result, so the flags are derived from it directly.
  always_comb begin
    diff_d = diff_q;
    diff_d[NIB_W*int'(idx_q) +: NIB_W] = nib_d;
  end

`ifdef NIBBLE_SUB_FLAGS_EN
  logic zero_q;
  logic ovf_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_SUB_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          diff_q <= diff_d;
          br_q   <= nib_bout;
          if (idx_q == IDX_LAST) begin
            bout_q      <= nib_bout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef NIBBLE_SUB_FLAGS_EN
            zero_q <= (diff_d == '0);
            ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated with rst so in_ready reads 0 for the whole reset cycle and rises
  // on the first cycle after reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
